// File: rtl/fetch_stall_ctrl_if.sv
// Fetch/decode boundary bundle: hazard and redirect requests in, fetch PC,
// F->D register and statistics out.
interface fetch_stall_ctrl_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] inst_f;
    logic [31:0] pc_f;
    logic [31:0] inst_d;
    logic [31:0] pc_d;
    logic        valid_d;
    logic        stall_active;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
    logic        wdog_err;

    modport master (
        output stall, redirect_valid, redirect_pc, inst_f,
        input  pc_f, inst_d, pc_d, valid_d, stall_active,
        input  stall_cycles, flush_count, wdog_err
    );

    modport slave (
        input  stall, redirect_valid, redirect_pc, inst_f,
        output pc_f, inst_d, pc_d, valid_d, stall_active,
        output stall_cycles, flush_count, wdog_err
    );
endinterface

// File: rtl/fetch_stall_ctrl.sv
// Fetch PC and F->D pipeline register with stall hold, redirect flush,
// bubble injection, saturating statistics and a stuck-stall watchdog.
module fetch_stall_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0100_0000,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013,
    parameter int          MAX_STALL = 16,
    parameter logic [31:0] PC_STEP   = 32'd4
) (
    input  logic              clock,
    input  logic              reset,
    fetch_stall_ctrl_if.slave bus
);
    localparam int             RL_W   = $clog2(MAX_STALL + 2);
    localparam logic [RL_W-1:0] RL_MAX = RL_W'(MAX_STALL + 1);
    localparam logic [RL_W-1:0] RL_TRIP = RL_W'(MAX_STALL - 1);

    typedef enum logic {RUN, STALL} state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_f_q, pc_f_d;
    logic [31:0]     inst_d_q, inst_d_d;
    logic [31:0]     pc_d_q, pc_d_d;
    logic            valid_d_q, valid_d_d;
    logic [31:0]     stall_cycles_q, stall_cycles_d;
    logic [31:0]     flush_count_q, flush_count_d;
    logic            wdog_err_q, wdog_err_d;
    logic [RL_W-1:0] run_len_q, run_len_d;

    always_comb begin
        state_d        = state_q;
        pc_f_d         = pc_f_q;
        inst_d_d       = inst_d_q;
        pc_d_d         = pc_d_q;
        valid_d_d      = valid_d_q;
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        wdog_err_d     = wdog_err_q;
        run_len_d      = run_len_q;

        if (bus.redirect_valid) begin
            // Redirect wins over stall; the flushed slot becomes a bubble.
            pc_f_d    = bus.redirect_pc;
            pc_d_d    = pc_f_q;
            inst_d_d  = NOP_INST;
            valid_d_d = 1'b0;
            state_d   = RUN;
            run_len_d = '0;
            if (flush_count_q != 32'hFFFF_FFFF)
                flush_count_d = flush_count_q + 32'd1;
        end else if (bus.stall) begin
            inst_d_d  = NOP_INST;
            valid_d_d = 1'b0;
            state_d   = STALL;
            if (stall_cycles_q != 32'hFFFF_FFFF)
                stall_cycles_d = stall_cycles_q + 32'd1;
            if (run_len_q != RL_MAX)
                run_len_d = run_len_q + 1'b1;
            // Trips on the edge where the run length reaches MAX_STALL.
            if (run_len_q >= RL_TRIP)
                wdog_err_d = 1'b1;
        end else begin
            inst_d_d  = bus.inst_f;
            pc_d_d    = pc_f_q;
            valid_d_d = 1'b1;
            pc_f_d    = pc_f_q + PC_STEP;
            state_d   = RUN;
            run_len_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= RUN;
            pc_f_q         <= RESET_PC;
            inst_d_q       <= NOP_INST;
            pc_d_q         <= RESET_PC;
            valid_d_q      <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
            wdog_err_q     <= 1'b0;
            run_len_q      <= '0;
        end else begin
            state_q        <= state_d;
            pc_f_q         <= pc_f_d;
            inst_d_q       <= inst_d_d;
            pc_d_q         <= pc_d_d;
            valid_d_q      <= valid_d_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
            wdog_err_q     <= wdog_err_d;
            run_len_q      <= run_len_d;
        end
    end

    assign bus.pc_f         = pc_f_q;
    assign bus.inst_d       = inst_d_q;
    assign bus.pc_d         = pc_d_q;
    assign bus.valid_d      = valid_d_q;
    assign bus.stall_active = (state_q == STALL);
    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;
    assign bus.wdog_err     = wdog_err_q;
endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Bench for fetch_stall_ctrl: directed vector table, watchdog sequences and
// randomized bursts checked against a behavioural model.
module tb_fetch_stall_ctrl;
    localparam logic [31:0] RESET_PC  = 32'h0100_0000;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam int          MAX_STALL = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fetch_stall_ctrl_if bus();

    fetch_stall_ctrl #(
        .RESET_PC(RESET_PC), .NOP_INST(NOP), .MAX_STALL(MAX_STALL), .PC_STEP(32'd4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_inst, m_pcd, m_sc, m_fc;
    logic        m_v, m_sa, m_wd;
    int          m_run;

    typedef struct {
        logic        rst, stl, rdv;
        logic [31:0] rpc, inst;
        logic [31:0] e_pc_f, e_inst_d, e_pc_d;
        logic        e_v, e_sa;
        logic [31:0] e_sc, e_fc;
        logic        e_wd;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_upd(input logic r, s, rv, input logic [31:0] rpc, inst);
        if (r) begin
            m_pc = RESET_PC; m_inst = NOP; m_pcd = RESET_PC; m_v = 0; m_sa = 0;
            m_sc = 0; m_fc = 0; m_wd = 0; m_run = 0;
        end else if (rv) begin
            m_pcd = m_pc; m_pc = rpc; m_inst = NOP; m_v = 0; m_sa = 0; m_run = 0;
            if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
        end else if (s) begin
            m_inst = NOP; m_v = 0; m_sa = 1; m_run++;
            if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            if (m_run >= MAX_STALL) m_wd = 1;
        end else begin
            m_inst = inst; m_pcd = m_pc; m_v = 1; m_pc = m_pc + 32'd4; m_sa = 0; m_run = 0;
        end
    endtask

    task automatic step(input logic r, s, rv, input logic [31:0] rpc, inst);
        reset = r; bus.stall = s; bus.redirect_valid = rv;
        bus.redirect_pc = rpc; bus.inst_f = inst;
        @(posedge clock);
        model_upd(r, s, rv, rpc, inst);
        @(negedge clock);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pc_f"},         bus.pc_f,         m_pc);
        chk({tag, ".inst_d"},       bus.inst_d,       m_inst);
        chk({tag, ".pc_d"},         bus.pc_d,         m_pcd);
        chk({tag, ".valid_d"},      32'(bus.valid_d), 32'(m_v));
        chk({tag, ".stall_active"}, 32'(bus.stall_active), 32'(m_sa));
        chk({tag, ".stall_cycles"}, bus.stall_cycles, m_sc);
        chk({tag, ".flush_count"},  bus.flush_count,  m_fc);
        chk({tag, ".wdog_err"},     32'(bus.wdog_err), 32'(m_wd));
    endtask

    initial begin
        bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0; bus.inst_f = 0;

        //          rst stl rdv rpc           inst          pc_f          inst_d        pc_d          v  sa sc     fc     wd
        vecs[0]  = '{1, 0, 0, 32'h0,         32'h0,        32'h0100_0000, NOP,         32'h0100_0000, 0, 0, 32'd0, 32'd0, 0};
        vecs[1]  = '{0, 0, 0, 32'h0,         32'h0050_0093, 32'h0100_0004, 32'h0050_0093, 32'h0100_0000, 1, 0, 32'd0, 32'd0, 0};
        vecs[2]  = '{0, 0, 0, 32'h0,         32'h0060_0113, 32'h0100_0008, 32'h0060_0113, 32'h0100_0004, 1, 0, 32'd0, 32'd0, 0};
        vecs[3]  = '{0, 1, 0, 32'h0,         32'hDEAD_BEEF, 32'h0100_0008, NOP,         32'h0100_0004, 0, 1, 32'd1, 32'd0, 0};
        vecs[4]  = '{0, 1, 0, 32'h0,         32'hDEAD_BEEF, 32'h0100_0008, NOP,         32'h0100_0004, 0, 1, 32'd2, 32'd0, 0};
        vecs[5]  = '{0, 0, 0, 32'h0,         32'h0070_0193, 32'h0100_000C, 32'h0070_0193, 32'h0100_0008, 1, 0, 32'd2, 32'd0, 0};
        vecs[6]  = '{0, 1, 1, 32'h0100_0040, 32'hDEAD_BEEF, 32'h0100_0040, NOP,         32'h0100_000C, 0, 0, 32'd2, 32'd1, 0};
        vecs[7]  = '{0, 0, 0, 32'h0,         32'h0080_0213, 32'h0100_0044, 32'h0080_0213, 32'h0100_0040, 1, 0, 32'd2, 32'd1, 0};
        vecs[8]  = '{0, 0, 1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'hFFFF_FFFC, NOP,         32'h0100_0044, 0, 0, 32'd2, 32'd2, 0};
        vecs[9]  = '{0, 0, 0, 32'h0,         32'h0090_0293, 32'h0000_0000, 32'h0090_0293, 32'hFFFF_FFFC, 1, 0, 32'd2, 32'd2, 0};
        vecs[10] = '{0, 1, 0, 32'h0,         32'hDEAD_BEEF, 32'h0000_0000, NOP,         32'hFFFF_FFFC, 0, 1, 32'd3, 32'd2, 0};
        vecs[11] = '{1, 1, 0, 32'h0,         32'hDEAD_BEEF, 32'h0100_0000, NOP,         32'h0100_0000, 0, 0, 32'd0, 32'd0, 0};

        @(negedge clock);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].stl, vecs[i].rdv, vecs[i].rpc, vecs[i].inst);
            chk($sformatf("vec%0d.pc_f", i),    bus.pc_f,   vecs[i].e_pc_f);
            chk($sformatf("vec%0d.inst_d", i),  bus.inst_d, vecs[i].e_inst_d);
            chk($sformatf("vec%0d.pc_d", i),    bus.pc_d,   vecs[i].e_pc_d);
            chk($sformatf("vec%0d.valid_d", i), 32'(bus.valid_d), 32'(vecs[i].e_v));
            chk($sformatf("vec%0d.stall_active", i), 32'(bus.stall_active), 32'(vecs[i].e_sa));
            chk($sformatf("vec%0d.stall_cycles", i), bus.stall_cycles, vecs[i].e_sc);
            chk($sformatf("vec%0d.flush_count", i),  bus.flush_count,  vecs[i].e_fc);
            chk($sformatf("vec%0d.wdog_err", i), 32'(bus.wdog_err), 32'(vecs[i].e_wd));
        end

        // Watchdog: 17-cycle stall trips on the 16th stalled edge and is sticky
        step(1, 0, 0, 0, 0);
        for (int k = 1; k <= 17; k++) begin
            step(0, 1, 0, 0, 32'h1111_1111);
            chk($sformatf("wd17.wdog_k%0d", k), 32'(bus.wdog_err), (k >= MAX_STALL) ? 32'd1 : 32'd0);
            chk($sformatf("wd17.sc_k%0d", k), bus.stall_cycles, 32'(k));
        end
        step(0, 0, 0, 0, 32'h0000_0033);
        chk("wd_release.wdog", 32'(bus.wdog_err), 32'd1);
        chk("wd_release.inst_d", bus.inst_d, 32'h0000_0033);
        chk("wd_release.pc_d", bus.pc_d, RESET_PC);
        step(0, 0, 1, 32'h0200_0000, 0);
        chk("wd_redirect.wdog", 32'(bus.wdog_err), 32'd1);
        step(1, 0, 0, 0, 0);
        chk("wd_reset.wdog", 32'(bus.wdog_err), 32'd0);

        // A single run cycle restarts the consecutive count
        for (int k = 0; k < 10; k++) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 32'h0000_0013);
        for (int k = 1; k <= 16; k++) begin
            step(0, 1, 0, 0, 0);
            chk($sformatf("wd_broken.wdog_k%0d", k), 32'(bus.wdog_err), (k >= 16) ? 32'd1 : 32'd0);
        end

        // A redirect (even with stall asserted) also restarts it
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 15; k++) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 32'h0300_0000, 0);
        chk("wd_redir.stall_active", 32'(bus.stall_active), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            step(0, 1, 0, 0, 0);
            chk($sformatf("wd_redir.wdog_k%0d", k), 32'(bus.wdog_err), (k >= 16) ? 32'd1 : 32'd0);
        end
        chk_model("post_directed");

        // Randomized bursts against the model
        step(1, 0, 0, 0, 0);
        for (int b = 0; b < 200; b++) begin
            int len;
            logic st;
            len = $urandom_range(1, 20);
            st  = 1'($urandom_range(0, 1));
            for (int j = 0; j < len; j++) begin
                logic r, rv;
                logic [31:0] rpc;
                r   = ($urandom_range(0, 199) == 0);
                rv  = ($urandom_range(0, 19) == 0);
                rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
                step(r, st, rv, rpc, $urandom);
                chk_model($sformatf("rnd_b%0d_c%0d", b, j));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
